// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - four-source priority interrupt controller with mask/pend/status registers
module int_ctrl #(
  parameter int            NSRC      = 4,
  parameter logic [3:0]    MASK_INIT = 4'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  irq_in,
  input  logic        reg_we,
  input  logic [1:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  input  logic        int_ack,
  input  logic        eret,
  output logic        interrupter,
  output logic [1:0]  irq_id
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t           r_state;
  logic [NSRC-1:0]  r_sync1;
  logic [NSRC-1:0]  r_sync2;
  logic [NSRC-1:0]  r_sync2_d;
  logic [NSRC-1:0]  r_pend;
  logic [NSRC-1:0]  r_mask;
  logic             r_interrupter;
  logic [1:0]       r_irq_id;

  logic [NSRC-1:0]  w_edge;
  logic [NSRC-1:0]  w_pm;
  logic [NSRC-1:0]  w_ack_clr;
  logic [NSRC-1:0]  w_w1c_clr;
  logic [1:0]       w_lowest;
  logic             w_in_service;
  logic             w_pending_any;

  // Two-flop synchronizer plus a delayed copy for rising-edge detection
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_sync2_d <= '0;
    end else begin
      r_sync1   <= irq_in;
      r_sync2   <= r_sync1;
      r_sync2_d <= r_sync2;
    end
  end

  assign w_edge    = r_sync2 & ~r_sync2_d;
  assign w_pm      = r_pend & r_mask;
  assign w_ack_clr = ((r_state == S_REQ) && int_ack) ? (4'b0001 << r_irq_id) : '0;
  assign w_w1c_clr = (reg_we && (reg_addr == 2'd1)) ? reg_wdata[NSRC-1:0] : '0;

  // Lowest set index of the unmasked pending bits; bit 0 has top priority
  always_comb begin
    w_lowest = 2'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (w_pm[i]) w_lowest = 2'(i);
    end
  end

  // Mask register: plain load on writes to address 0
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mask <= MASK_INIT;
    end else if (reg_we && (reg_addr == 2'd0)) begin
      r_mask <= reg_wdata[NSRC-1:0];
    end
  end

  // Pending bits: a new edge wins over a same-cycle ack or write-1-to-clear
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pend <= '0;
    end else begin
      r_pend <= (r_pend & ~(w_ack_clr | w_w1c_clr)) | w_edge;
    end
  end

  // Request/service FSM with registered interrupter and latched source index
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_interrupter <= 1'b0;
      r_irq_id      <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|w_pm) begin
            r_state       <= S_REQ;
            r_interrupter <= 1'b1;
            r_irq_id      <= w_lowest;
          end
        end
        S_REQ: begin
          if (int_ack) begin
            r_state       <= S_SERVICE;
            r_interrupter <= 1'b0;
          end else if (!w_pm[r_irq_id]) begin
            r_state       <= S_IDLE;
            r_interrupter <= 1'b0;
          end
        end
        S_SERVICE: begin
          if (eret) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state       <= S_IDLE;
          r_interrupter <= 1'b0;
        end
      endcase
    end
  end

  assign w_in_service  = (r_state == S_SERVICE);
  assign w_pending_any = |r_pend;

  // Register read mux; unused address and upper bits read as zero
  always_comb begin
    reg_rdata = 32'd0;
    case (reg_addr)
      2'd0:    reg_rdata = {28'd0, r_mask};
      2'd1:    reg_rdata = {28'd0, r_pend};
      2'd2:    reg_rdata = {28'd0, w_in_service, w_pending_any, r_irq_id};
      default: reg_rdata = 32'd0;
    endcase
  end

  assign interrupter = r_interrupter;
  assign irq_id      = r_irq_id;

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - directed scoreboard bench for int_ctrl
module tb_int_ctrl;

  logic        clk;
  logic        rst;
  logic [3:0]  irq_in;
  logic        reg_we;
  logic [1:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        int_ack;
  logic        eret;
  logic        interrupter;
  logic [1:0]  irq_id;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  int_ctrl #(.NSRC(4), .MASK_INIT(4'h0)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .reg_we(reg_we), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .int_ack(int_ack), .eret(eret),
    .interrupter(interrupter), .irq_id(irq_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    e = sb.pop_front();
    checks++;
    assert (obs === e.val) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", e.tag, obs, e.val);
    end
  endtask

  task automatic rd_check(input logic [1:0] addr, input string tag, input logic [31:0] v);
    push(tag, v);
    reg_addr = addr;
    #1;
    pop_check(reg_rdata);
  endtask

  task automatic out_check(input string tag, input logic irq_exp, input logic [1:0] id_exp);
    push({tag, "_irq"}, {31'd0, irq_exp});
    push({tag, "_id"}, {30'd0, id_exp});
    pop_check({31'd0, interrupter});
    pop_check({30'd0, irq_id});
  endtask

  task automatic wr(input logic [1:0] addr, input logic [3:0] d);
    reg_we = 1'b1;
    reg_addr = addr;
    reg_wdata = {28'd0, d};
    tick();
    reg_we = 1'b0;
    reg_wdata = 32'd0;
  endtask

  task automatic pulse_ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  task automatic pulse_eret();
    eret = 1'b1;
    tick();
    eret = 1'b0;
  endtask

  initial begin
    rst = 1'b0; irq_in = 4'd0; reg_we = 1'b0; reg_addr = 2'd0;
    reg_wdata = 32'd0; int_ack = 1'b0; eret = 1'b0;
    tick();
    tick();
    rst = 1'b1;

    // reset state
    out_check("rst", 1'b0, 2'd0);
    rd_check(2'd0, "rst_mask", 32'h0);
    rd_check(2'd1, "rst_pend", 32'h0);
    rd_check(2'd2, "rst_stat", 32'h0);

    // single edge on source 2: pend after E2, request after E3
    wr(2'd0, 4'hF);
    rd_check(2'd0, "mask_f", 32'hF);
    irq_in = 4'b0100;
    tick();
    irq_in = 4'b0000;
    tick();
    rd_check(2'd1, "e1_pend", 32'h0);
    tick();
    rd_check(2'd1, "e2_pend", 32'h4);
    out_check("e2", 1'b0, 2'd0);
    tick();
    out_check("e3", 1'b1, 2'd2);
    rd_check(2'd2, "e3_stat", 32'h6);
    pulse_ack();
    out_check("ack2", 1'b0, 2'd2);
    rd_check(2'd1, "ack2_pend", 32'h0);
    rd_check(2'd2, "ack2_stat", 32'hA);
    pulse_ack();
    rd_check(2'd2, "stray_ack_stat", 32'hA);
    pulse_eret();
    rd_check(2'd2, "eret2_stat", 32'h2);
    pulse_eret();
    out_check("stray_eret", 1'b0, 2'd2);

    // simultaneous edges on 3 and 1: 1 wins, 3 follows after eret
    irq_in = 4'b1010;
    tick();
    irq_in = 4'b0000;
    tick();
    tick();
    rd_check(2'd1, "dual_pend", 32'hA);
    tick();
    out_check("dual_req", 1'b1, 2'd1);
    pulse_ack();
    rd_check(2'd1, "dual_ack_pend", 32'h8);
    rd_check(2'd2, "dual_stat", 32'hD);
    pulse_eret();
    out_check("dual_eret", 1'b0, 2'd1);
    tick();
    out_check("req3", 1'b1, 2'd3);

    // masking the presented source withdraws the request, id holds
    wr(2'd0, 4'b0111);
    out_check("mask3_w", 1'b1, 2'd3);
    tick();
    out_check("mask3_idle", 1'b0, 2'd3);
    wr(2'd1, 4'b1000);
    rd_check(2'd1, "w1c3_pend", 32'h0);

    // edge on masked source pends; unmasking raises request two edges later
    wr(2'd0, 4'h0);
    irq_in = 4'b0001;
    tick();
    irq_in = 4'b0000;
    tick();
    tick();
    tick();
    rd_check(2'd1, "masked_pend", 32'h1);
    out_check("masked", 1'b0, 2'd3);
    wr(2'd0, 4'h1);
    out_check("unmask_w", 1'b0, 2'd3);
    tick();
    out_check("unmask_req", 1'b1, 2'd0);
    pulse_ack();
    pulse_eret();

    // W1C while in REQ for id 2
    wr(2'd0, 4'hF);
    irq_in = 4'b0100;
    tick();
    irq_in = 4'b0000;
    tick();
    tick();
    tick();
    out_check("req2b", 1'b1, 2'd2);
    wr(2'd1, 4'b0100);
    rd_check(2'd1, "w1c2_pend", 32'h0);
    tick();
    out_check("w1c2_idle", 1'b0, 2'd2);

    // edge and W1C on the same bit in the same cycle: set wins
    irq_in = 4'b0100;
    tick();
    irq_in = 4'b0000;
    tick();
    wr(2'd1, 4'b0100);
    rd_check(2'd1, "set_wins_pend", 32'h4);
    tick();
    out_check("set_wins_req", 1'b1, 2'd2);
    pulse_ack();
    pulse_eret();

    // a held level pends exactly once
    irq_in = 4'b0001;
    tick();
    tick();
    tick();
    tick();
    out_check("level_req", 1'b1, 2'd0);
    pulse_ack();
    for (int i = 0; i < 5; i++) tick();
    rd_check(2'd1, "level_once", 32'h0);
    irq_in = 4'b0000;
    rd_check(2'd2, "level_stat", 32'h8);

    // reset while in SERVICE abandons it
    rst = 1'b0;
    tick();
    rst = 1'b1;
    out_check("rst_svc", 1'b0, 2'd0);
    rd_check(2'd2, "rst_svc_stat", 32'h0);
    rd_check(2'd0, "rst_svc_mask", 32'h0);
    rd_check(2'd1, "rst_svc_pend", 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
